// File: rtl/sram_ctrl_burst.sv
// Async-SRAM controller with setup/strobe/hold wait states.
// Handles single and burst accesses with address auto-increment and wrap.
module sram_ctrl_burst #(
    parameter int ADDR_WIDTH    = 19,
    parameter int DATA_WIDTH    = 8,
    parameter int BURST_WIDTH   = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_operation,
    input  logic                   rw,
    input  logic [ADDR_WIDTH-1:0]  address_input,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic [DATA_WIDTH-1:0]  data_f2s,
    output logic                   ready,
    output logic                   done,
    output logic                   rdata_valid,
    output logic                   wdata_req,
    output logic [DATA_WIDTH-1:0]  data_s2f,
    output logic [ADDR_WIDTH-1:0]  address_to_sram_output,
    output logic                   ce_to_sram_output,
    output logic                   oe_to_sram_output,
    output logic                   we_to_sram_output,
    inout  wire  [DATA_WIDTH-1:0]  data_from_to_sram_input_output
);

    // Zero-length phases are stretched to one cycle.
    localparam int S_EFF = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
    localparam int A_EFF = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
    localparam int H_EFF = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
    localparam int M_SA  = (S_EFF > A_EFF) ? S_EFF : A_EFF;
    localparam int MAXC  = (M_SA > H_EFF) ? M_SA : H_EFF;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] S_LD = CW'(S_EFF - 1);
    localparam logic [CW-1:0] A_LD = CW'(A_EFF - 1);
    localparam logic [CW-1:0] H_LD = CW'(H_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BURST_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   done_q, done_d;
    logic                   bus_drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            left_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        left_d  = left_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_operation) begin
                    state_d = SETUP;
                    cnt_d   = S_LD;
                    rw_d    = rw;
                    addr_d  = address_input;
                    left_d  = burst_len;
                    wdata_d = data_f2s;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = A_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = H_LD;
                    if (rw_q) begin
                        rdata_d = data_from_to_sram_input_output;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (left_q != '0) begin
                    // ce stays low straight into the next word
                    state_d = SETUP;
                    cnt_d   = S_LD;
                    left_d  = left_q - BURST_WIDTH'(1);
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    if (!rw_q) begin
                        wdata_d = data_f2s;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready       = (state_q == IDLE);
    assign done        = done_q;
    assign data_s2f    = rdata_q;
    assign rdata_valid = (state_q == HOLD) && (cnt_q == H_LD) && rw_q;
    assign wdata_req   = (state_q == STROBE) && (cnt_q == A_LD)
                         && !rw_q && (left_q != '0);

    assign address_to_sram_output = addr_q;
    assign ce_to_sram_output      = (state_q == IDLE);
    assign oe_to_sram_output      = !((state_q == STROBE) && rw_q);
    assign we_to_sram_output      = !((state_q == STROBE) && !rw_q);

    assign bus_drive = (state_q != IDLE) && !rw_q;
    assign data_from_to_sram_input_output = bus_drive ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl_burst.sv
// Directed bench for sram_ctrl_burst with a behavioural async-SRAM model.
// Checks pin timing, burst addressing, handshakes and reset abort.
module tb_sram_ctrl_burst;

    logic        clk;
    logic        rst_n;
    logic        start_operation;
    logic        rw;
    logic [18:0] address_input;
    logic [3:0]  burst_len;
    logic [7:0]  data_f2s;
    logic        ready;
    logic        done;
    logic        rdata_valid;
    logic        wdata_req;
    logic [7:0]  data_s2f;
    logic [18:0] sram_a;
    logic        sram_ce;
    logic        sram_oe;
    logic        sram_we;
    wire  [7:0]  sram_dq;

    int n_tests = 0;
    int n_fail  = 0;

    sram_ctrl_burst dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .start_operation                (start_operation),
        .rw                             (rw),
        .address_input                  (address_input),
        .burst_len                      (burst_len),
        .data_f2s                       (data_f2s),
        .ready                          (ready),
        .done                           (done),
        .rdata_valid                    (rdata_valid),
        .wdata_req                      (wdata_req),
        .data_s2f                       (data_s2f),
        .address_to_sram_output         (sram_a),
        .ce_to_sram_output              (sram_ce),
        .oe_to_sram_output              (sram_oe),
        .we_to_sram_output              (sram_we),
        .data_from_to_sram_input_output (sram_dq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives on read, latches data on the rising edge of we
    logic [7:0] mem [0:524287];
    assign sram_dq = (!sram_ce && !sram_oe && sram_we) ? mem[sram_a] : 'z;
    always @(posedge sram_we) begin
        if (!sram_ce) mem[sram_a] <= sram_dq;
    end

    // Cumulative pin monitor sampled on the falling edge
    int c_ce, c_oe, c_we, c_both, c_rv, c_wreq, c_done, c_cerise, c_bus;
    logic [7:0]  exp_bus;
    logic        ce_prev;
    logic [7:0]  rd_data [$];
    logic [18:0] rd_addr [$];

    initial begin
        c_ce = 0; c_oe = 0; c_we = 0; c_both = 0; c_rv = 0;
        c_wreq = 0; c_done = 0; c_cerise = 0; c_bus = 0;
        ce_prev = 1'b1;
    end

    always @(negedge clk) begin
        if (!sram_ce) c_ce++;
        if (!sram_oe) c_oe++;
        if (!sram_we) c_we++;
        if (!sram_oe && !sram_we) c_both++;
        if (sram_ce && !ce_prev) c_cerise++;
        if (!sram_ce && sram_dq == exp_bus) c_bus++;
        if (wdata_req) c_wreq++;
        if (done) c_done++;
        if (rdata_valid) begin
            c_rv++;
            rd_data.push_back(data_s2f);
            rd_addr.push_back(sram_a);
        end
        ce_prev = sram_ce;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int d_ce, d_oe, d_we, d_both, d_rv, d_wreq, d_done, d_cerise, d_bus;
    int rd_base;

    // Issue one operation from a falling-edge-aligned point and wait for done.
    task automatic op(input logic r, input logic [18:0] a,
                      input logic [3:0] bl, input logic [7:0] w0,
                      input logic [7:0] w1, input bit poke,
                      output int lat);
        int b_ce, b_oe, b_we, b_both, b_rv, b_wreq, b_done, b_rise, b_bus;
        bit got;
        check("ready_before_start", {31'd0, ready}, 32'd1);
        rw = r;
        address_input = a;
        burst_len = bl;
        data_f2s = w0;
        start_operation = 1'b1;
        @(posedge clk);
        #1;
        start_operation = 1'b0;
        b_ce = c_ce; b_oe = c_oe; b_we = c_we; b_both = c_both;
        b_rv = c_rv; b_wreq = c_wreq; b_done = c_done;
        b_rise = c_cerise; b_bus = c_bus;
        rd_base = rd_data.size();
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (wdata_req) data_f2s = w1;
            if (poke) begin
                start_operation = (lat == 2);
                address_input = 19'h55555;
            end
            if (done) got = 1'b1;
        end
        start_operation = 1'b0;
        #1;
        check("done_seen", {31'd0, got}, 32'd1);
        check("ready_on_done", {31'd0, ready}, 32'd1);
        d_ce = c_ce - b_ce; d_oe = c_oe - b_oe; d_we = c_we - b_we;
        d_both = c_both - b_both; d_rv = c_rv - b_rv;
        d_wreq = c_wreq - b_wreq; d_done = c_done - b_done;
        d_cerise = c_cerise - b_rise; d_bus = c_bus - b_bus;
    endtask

    initial begin
        int lat;
        int b_done;
        int k;
        rst_n = 1'b0;
        start_operation = 1'b0;
        rw = 1'b0;
        address_input = '0;
        burst_len = '0;
        data_f2s = '0;
        exp_bus = 8'h00;
        mem[19'h00010] = 8'h5A;
        mem[19'h7FFFE] = 8'h01;
        mem[19'h7FFFF] = 8'h02;
        mem[19'h00000] = 8'h03;
        mem[19'h00001] = 8'h04;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_ce", {31'd0, sram_ce}, 32'd1);
        check("rst_oe", {31'd0, sram_oe}, 32'd1);
        check("rst_we", {31'd0, sram_we}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        check("rst_wreq", {31'd0, wdata_req}, 32'd0);
        check("rst_rdata", {24'd0, data_s2f}, 32'd0);
        check("rst_addr", {13'd0, sram_a}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write
        exp_bus = 8'hA5;
        op(1'b0, 19'h12345, 4'd0, 8'hA5, 8'h00, 1'b0, lat);
        check("wr1_latency", lat, 4);
        check("wr1_ce_low", d_ce, 4);
        check("wr1_we_low", d_we, 2);
        check("wr1_oe_low", d_oe, 0);
        check("wr1_bus", d_bus, 4);
        check("wr1_wreq", d_wreq, 0);
        check("wr1_done", d_done, 1);
        check("wr1_mem", {24'd0, mem[19'h12345]}, 32'hA5);

        // Single read, accepted on the done cycle of the write
        exp_bus = 8'hEE;
        op(1'b1, 19'h00010, 4'd0, 8'h00, 8'h00, 1'b0, lat);
        check("rd1_latency", lat, 4);
        check("rd1_oe_low", d_oe, 2);
        check("rd1_we_low", d_we, 0);
        check("rd1_rvalid", d_rv, 1);
        check("rd1_data", {24'd0, rd_data[rd_base]}, 32'h5A);
        check("rd1_data_s2f", {24'd0, data_s2f}, 32'h5A);

        // Burst read across the address wrap
        op(1'b1, 19'h7FFFE, 4'd3, 8'h00, 8'h00, 1'b0, lat);
        check("brd_latency", lat, 16);
        check("brd_ce_low", d_ce, 16);
        check("brd_ce_rise", d_cerise, 1);
        check("brd_oe_low", d_oe, 8);
        check("brd_rvalid", d_rv, 4);
        check("brd_done", d_done, 1);
        if (rd_data.size() >= rd_base + 4) begin
            for (int i = 0; i < 4; i++) begin
                logic [18:0] ea;
                ea = 19'h7FFFE + 19'(i);
                check("brd_addr", {13'd0, rd_addr[rd_base + i]}, {13'd0, ea});
                check("brd_data", {24'd0, rd_data[rd_base + i]}, 32'(i + 1));
            end
        end else begin
            check("brd_word_count", rd_data.size() - rd_base, 4);
        end

        // Burst write with ignored start pulses mid-burst
        op(1'b0, 19'h00100, 4'd1, 8'h11, 8'h22, 1'b1, lat);
        check("bwr_latency", lat, 8);
        check("bwr_wreq", d_wreq, 1);
        check("bwr_done", d_done, 1);
        check("bwr_we_low", d_we, 4);
        check("bwr_ce_rise", d_cerise, 1);
        check("bwr_mem0", {24'd0, mem[19'h00100]}, 32'h11);
        check("bwr_mem1", {24'd0, mem[19'h00101]}, 32'h22);
        @(negedge clk);
        check("bwr_no_restart", {31'd0, ready}, 32'd1);
        check("bwr_poke_addr", {24'd0, mem[19'h55555]}, 32'h00);

        // Write then read-back on the done cycle
        op(1'b0, 19'h00300, 4'd0, 8'h3C, 8'h00, 1'b0, lat);
        op(1'b1, 19'h00300, 4'd0, 8'h00, 8'h00, 1'b0, lat);
        check("wr_rd_latency", lat, 4);
        check("wr_rd_data", {24'd0, data_s2f}, 32'h3C);
        check("wr_rd_no_overlap", d_both, 0);

        // Reset while we is low
        @(negedge clk);
        rw = 1'b0;
        address_input = 19'h00200;
        data_f2s = 8'h77;
        burst_len = 4'd2;
        start_operation = 1'b1;
        @(posedge clk);
        #1;
        start_operation = 1'b0;
        k = 0;
        while (k < 20 && sram_we) begin
            @(negedge clk);
            k++;
        end
        check("abort_we_seen", {31'd0, sram_we}, 32'd0);
        b_done = c_done;
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'd0, sram_we}, 32'd1);
        check("abort_ce", {31'd0, sram_ce}, 32'd1);
        check("abort_oe", {31'd0, sram_oe}, 32'd1);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_rdata", {24'd0, data_s2f}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", c_done - b_done, 0);
        #1;
        op(1'b1, 19'h00010, 4'd0, 8'h00, 8'h00, 1'b0, lat);
        check("post_rd_latency", lat, 4);
        check("post_rd_data", {24'd0, data_s2f}, 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
